// File: rtl/taylor_pkg.sv
// Shared types and constant helpers for the Horner-form Taylor sine/cosine evaluator.
// Optional angle folding is selected with TAYLOR_RANGE_REDUCE_EN (see taylor_trig_horner).
package taylor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REDUCE,
      ST_SQUARE,
      ST_ITER_A,
      ST_ITER_B,
      ST_SCALE,
      ST_FINISH,
      ST_DONE
   } state_t;

   localparam int unsigned K_W = 3;

   // pi scaled by 2^32, rounded
   localparam longint PI_Q32 = 64'sd13493037705;

   // Horner coefficient 1/((2k-1)(2k)) for cosine or 1/((2k)(2k+1)) for sine, rounded to FRAC bits
   function automatic longint coef(input int unsigned k, input bit is_sin, input int unsigned frac);
      longint d;
      if (is_sin) d = longint'(2 * k) * longint'(2 * k + 1);
      else        d = longint'(2 * k - 1) * longint'(2 * k);
      return ((longint'(1) <<< frac) + d / 2) / d;
   endfunction

   function automatic longint one_fx(input int unsigned frac);
      return longint'(1) <<< frac;
   endfunction

   function automatic longint pi_fx(input int unsigned frac);
      if (frac >= 32) return PI_Q32 <<< (frac - 32);
      return (PI_Q32 + (longint'(1) <<< (31 - frac))) >>> (32 - frac);
   endfunction

   function automatic longint half_pi_fx(input int unsigned frac);
      if (frac >= 33) return PI_Q32 <<< (frac - 33);
      return (PI_Q32 + (longint'(1) <<< (32 - frac))) >>> (33 - frac);
   endfunction

   function automatic bit params_ok(input int unsigned width, input int unsigned frac,
                                    input int unsigned terms);
      return (frac >= 4) && (frac + 3 <= width) && (terms >= 2) && (terms <= 8);
   endfunction

endpackage

// File: rtl/taylor_fxp_mul.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC,
// saturate to the signed WIDTH range.
module taylor_fxp_mul #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned FRAC  = 10
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] product_c
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [PW-1:0] full;
   logic signed [PW-1:0] shifted;
   logic                 fits;

   always_comb begin
      full    = PW'(a) * PW'(b);
      shifted = full >>> FRAC;
      // result fits when every bit above the WIDTH-1 sign position matches it
      fits    = (&shifted[PW-1:WIDTH-1]) || ~(|shifted[PW-1:WIDTH-1]);
      if (fits)            product_c = shifted[WIDTH-1:0];
      else if (shifted[PW-1]) product_c = MIN_V;
      else                 product_c = MAX_V;
   end

endmodule

// File: rtl/taylor_trig_horner.sv
// Sequential sine/cosine via Horner-form Taylor series on one shared fixed-point multiplier.
// Define TAYLOR_RANGE_REDUCE_EN to fold |angle| > pi/2 back into range (adds one cycle).
module taylor_trig_horner
   import taylor_pkg::*;
#(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned FRAC  = 10,
   parameter int unsigned TERMS = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] angle_in,
   output logic                    busy_out,
   output logic                    ready_out,
   output logic signed [WIDTH-1:0] result_out
);

   localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(one_fx(FRAC));
   localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   if (!params_ok(WIDTH, FRAC, TERMS)) begin : g_bad_params
      $error("taylor_trig_horner: illegal WIDTH/FRAC/TERMS combination");
   end

   state_t                  state;
   logic [K_W-1:0]          k;
   logic signed [WIDTH-1:0] x;
   logic signed [WIDTH-1:0] x2;
   logic signed [WIDTH-1:0] acc;
   logic signed [WIDTH-1:0] t;
   logic                    is_sin;
   logic                    neg;

   logic signed [WIDTH-1:0] mul_a;
   logic signed [WIDTH-1:0] mul_b;
   logic signed [WIDTH-1:0] prod;
   logic signed [WIDTH-1:0] coef_k;
   logic signed [WIDTH-1:0] acc_neg;

   // constant coefficient tables indexed by k; entry 0 is never selected
   logic signed [WIDTH-1:0] cos_tab [8];
   logic signed [WIDTH-1:0] sin_tab [8];

   for (genvar i = 0; i < 8; i++) begin : g_coef
      if (i == 0) begin : g_zero
         assign cos_tab[i] = '0;
         assign sin_tab[i] = '0;
      end else begin : g_val
         assign cos_tab[i] = WIDTH'(coef(i, 1'b0, FRAC));
         assign sin_tab[i] = WIDTH'(coef(i, 1'b1, FRAC));
      end
   end

   assign coef_k  = is_sin ? sin_tab[k] : cos_tab[k];
   assign acc_neg = (acc == MIN_V) ? MAX_V : -acc;

`ifdef TAYLOR_RANGE_REDUCE_EN
   localparam logic signed [WIDTH-1:0] PI      = WIDTH'(pi_fx(FRAC));
   localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(half_pi_fx(FRAC));

   logic signed [WIDTH-1:0] x_fold;
   logic                    fold;

   // mirror the angle about +/-pi/2 so the series stays in its accurate range
   always_comb begin
      x_fold = x;
      fold   = 1'b0;
      if (x > HALF_PI) begin
         x_fold = PI - x;
         fold   = 1'b1;
      end else if (x < -HALF_PI) begin
         x_fold = -PI - x;
         fold   = 1'b1;
      end
   end
`endif

   // operand routing for the single shared multiplier
   always_comb begin
      mul_a = x;
      mul_b = x;
      case (state)
         ST_ITER_A: begin
            mul_a = acc;
            mul_b = coef_k;
         end
         ST_ITER_B: begin
            mul_a = t;
            mul_b = x2;
         end
         ST_SCALE: begin
            mul_a = acc;
            mul_b = x;
         end
         default: ;
      endcase
   end

   taylor_fxp_mul #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mul (
      .a         (mul_a),
      .b         (mul_b),
      .product_c (prod)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         k          <= '0;
         x          <= '0;
         x2         <= '0;
         acc        <= '0;
         t          <= '0;
         is_sin     <= 1'b0;
         neg        <= 1'b0;
         busy_out   <= 1'b0;
         ready_out  <= 1'b0;
         result_out <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  x         <= angle_in;
                  is_sin    <= mode;
                  acc       <= ONE;
                  k         <= K_W'(TERMS - 1);
                  neg       <= 1'b0;
                  busy_out  <= 1'b1;
                  ready_out <= 1'b0;
`ifdef TAYLOR_RANGE_REDUCE_EN
                  state     <= ST_REDUCE;
`else
                  state     <= ST_SQUARE;
`endif
               end
            end
`ifdef TAYLOR_RANGE_REDUCE_EN
            ST_REDUCE: begin
               x     <= x_fold;
               neg   <= fold & ~is_sin;
               state <= ST_SQUARE;
            end
`endif
            ST_SQUARE: begin
               x2    <= prod;
               state <= ST_ITER_A;
            end
            ST_ITER_A: begin
               t     <= prod;
               state <= ST_ITER_B;
            end
            ST_ITER_B: begin
               acc <= ONE - prod;
               if (k == K_W'(1)) begin
                  state <= is_sin ? ST_SCALE : ST_FINISH;
               end else begin
                  k     <= k - K_W'(1);
                  state <= ST_ITER_A;
               end
            end
            ST_SCALE: begin
               acc   <= prod;
               state <= ST_FINISH;
            end
            // publish the result with the fold sign applied
            ST_FINISH: begin
               result_out <= neg ? acc_neg : acc;
               ready_out  <= 1'b1;
               busy_out   <= 1'b0;
               state      <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_taylor_trig_horner.sv
// Directed bench for taylor_trig_horner: scoreboard of expected results checked on ready_out.
module tb_taylor_trig_horner;

`ifdef TAYLOR_RANGE_REDUCE_EN
   localparam int LAT_EXTRA = 1;
`else
   localparam int LAT_EXTRA = 0;
`endif

   logic               clock;
   logic               reset;
   logic               start;
   logic               mode;
   logic signed [23:0] angle_in;
   logic               busy_out;
   logic               ready_out;
   logic signed [23:0] result_out;

   typedef struct {
      int    exact;
      int    refv;
      int    tol;
      int    lat;
      int    cap;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc_cnt  = 0;
   int   last_res = 0;

   taylor_trig_horner #(
      .WIDTH (24),
      .FRAC  (10),
      .TERMS (5)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .angle_in   (angle_in),
      .busy_out   (busy_out),
      .ready_out  (ready_out),
      .result_out (result_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   // reference arithmetic for Q.10 words
   function automatic int fmul(input int a, input int b);
      longint p;
      p = (longint'(a) * longint'(b)) >>> 10;
      if (p > 64'sd8388607)  p = 64'sd8388607;
      if (p < -64'sd8388608) p = -64'sd8388608;
      return int'(p);
   endfunction

   function automatic int fcoef(input int k, input bit s);
      int d;
      d = s ? (2 * k) * (2 * k + 1) : (2 * k - 1) * (2 * k);
      return (2048 + d) / (2 * d);
   endfunction

   function automatic int model(input int ang, input bit s);
      int x, x2, acc, t;
      bit neg;
      x   = ang;
      neg = 1'b0;
`ifdef TAYLOR_RANGE_REDUCE_EN
      if (x > 1608) begin
         x = 3217 - x;  neg = !s;
      end else if (x < -1608) begin
         x = -3217 - x; neg = !s;
      end
`endif
      x2  = fmul(x, x);
      acc = 1024;
      for (int k = 4; k >= 1; k--) begin
         t   = fmul(acc, fcoef(k, s));
         acc = 1024 - fmul(t, x2);
      end
      if (s) acc = fmul(acc, x);
      if (neg) acc = -acc;
      return acc;
   endfunction

   task automatic check(input string tag, input string what,
                        input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s %s: observed %0d expected %0d", tag, what, obs, expv);
      end
   endtask

   task automatic check_tol(input string tag, input int obs, input int refv, input int tol);
      int d;
      d = obs - refv;
      if (d < 0) d = -d;
      n_assert++;
      assert (d <= tol) else begin
         n_fail++;
         $error("FAIL %s accuracy: observed %0d expected %0d +/- %0d", tag, obs, refv, tol);
      end
   endtask

   task automatic start_op(input int ang, input bit s, input int refv, input int tol,
                           input string tag);
      exp_t e;
      @(negedge clock);
      start    = 1'b1;
      mode     = s;
      angle_in = 24'(ang);
      e.exact  = model(ang, s);
      e.refv   = refv;
      e.tol    = tol;
      e.lat    = 10 + int'(s) + LAT_EXTRA;
      e.tag    = tag;
      @(posedge clock);
      #1;
      e.cap = cyc_cnt;
      sb.push_back(e);
      check(tag, "ready after capture", 32'(ready_out), 0);
      check(tag, "busy after capture", 32'(busy_out), 1);
      check(tag, "result held", 32'(result_out), last_res);
      start    = 1'b0;
      mode     = 1'($urandom);
      angle_in = 24'($urandom);
   endtask

   task automatic wait_result();
      exp_t e;
      bit   got;
      bit   busy_bad;
      got      = 1'b0;
      busy_bad = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clock);
         #1;
         if (ready_out) got = 1'b1;
         else if (!busy_out) busy_bad = 1'b1;
      end
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      check(e.tag, "ready seen", 32'(got), 1);
      if (got) begin
         check(e.tag, "latency", cyc_cnt - e.cap, e.lat);
         check(e.tag, "busy during run", 32'(busy_bad), 0);
         check(e.tag, "busy at done", 32'(busy_out), 0);
         check(e.tag, "exact result", 32'(result_out), e.exact);
         check_tol(e.tag, int'(result_out), e.refv, e.tol);
      end
      last_res = e.exact;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clock    = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      mode     = 1'b0;
      angle_in = '0;
      #1 reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check("reset", "ready", 32'(ready_out), 0);
         check("reset", "busy", 32'(busy_out), 0);
         check("reset", "result", 32'(result_out), 0);
      end

      start_op(512, 1'b0, 899, 3, "cos_0p5");    wait_result();
      start_op(512, 1'b1, 491, 3, "sin_0p5");    wait_result();
      start_op(0, 1'b0, 1024, 0, "cos_0");       wait_result();
      start_op(0, 1'b1, 0, 0, "sin_0");          wait_result();
      start_op(1608, 1'b0, 0, 3, "cos_hpi");     wait_result();
      start_op(1608, 1'b1, 1024, 3, "sin_hpi");  wait_result();
      start_op(-1608, 1'b1, -1024, 3, "sin_mhpi"); wait_result();

      // second start while busy must not disturb the run
      start_op(512, 1'b0, 899, 3, "cos_ignore");
      repeat (3) @(negedge clock);
      start    = 1'b1;
      mode     = 1'b0;
      angle_in = '0;
      @(negedge clock);
      start = 1'b0;
      wait_result();

      for (int i = 0; i < 4; i++) begin
         int a;
         bit s;
         a = int'($urandom_range(3216)) - 1608;
         s = 1'($urandom);
         start_op(a, s, model(a, s), 0, "rand");
         wait_result();
      end

      // reset in the middle of a run
      start_op(512, 1'b0, 899, 3, "cos_abort");
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_reset", "ready", 32'(ready_out), 0);
      check("mid_reset", "busy", 32'(busy_out), 0);
      check("mid_reset", "result", 32'(result_out), 0);
      sb.delete();
      last_res = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("post_reset", "busy", 32'(busy_out), 0);
      check("post_reset", "ready", 32'(ready_out), 0);
      start_op(0, 1'b1, 0, 0, "sin_after_reset"); wait_result();

`ifdef TAYLOR_RANGE_REDUCE_EN
      start_op(2560, 1'b0, -820, 4, "cos_2p5");  wait_result();
      start_op(2560, 1'b1, 613, 4, "sin_2p5");   wait_result();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
